// File: rtl/rtc_bus_pkg.sv
// Shared encodings, FSM states and register tables for the RTC bus sequencer.
// Defining RTC_TIMER_EN adds the timer registers 0x41-0x43 to read-poll and program frames.
package rtc_bus_pkg;

    typedef enum logic [1:0] {
        CtlI  = 2'b00,
        CtlL  = 2'b01,
        CtlE  = 2'b10,
        CtlMs = 2'b11
    } ctl_e;

    typedef enum logic [2:0] {
        StIdle, StASet, StAStb, StAHld, StDSet, StDStb, StDHld, StNext
    } state_e;

    localparam logic [3:0] InitLast = 4'd3;
`ifdef RTC_TIMER_EN
    localparam logic [3:0] TimeLast = 4'd8;
`else
    localparam logic [3:0] TimeLast = 4'd5;
`endif

    function automatic logic [7:0] frame_addr(ctl_e frame, logic [3:0] idx);
        logic [7:0] addr;
        if (frame == CtlI) begin
            case (idx[1:0])
                2'd0:    addr = 8'h02;
                2'd1:    addr = 8'h02;
                2'd2:    addr = 8'h10;
                default: addr = 8'h00;
            endcase
        end
`ifdef RTC_TIMER_EN
        else if (idx >= 4'd6) begin
            addr = 8'h41 + {4'h0, idx - 4'd6};
        end
`endif
        else begin
            addr = 8'h21 + {4'h0, idx};
        end
        return addr;
    endfunction

    function automatic logic [7:0] init_data(logic [1:0] idx);
        logic [7:0] data;
        case (idx)
            2'd0:    data = 8'h10;
            2'd1:    data = 8'h00;
            2'd2:    data = 8'hD2;
            default: data = 8'h00;
        endcase
        return data;
    endfunction

endpackage

// File: rtl/rtc_bus_timer.sv
// Loadable down-counter timing each bus phase; holds at zero and flags it.
module rtc_bus_timer #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/rtc_bus_sequencer.sv
// Turns the Control state into RTC bus frames: per register an address phase then a data phase.
// Build with RTC_TIMER_EN defined to include timer registers in L/E frames.
module rtc_bus_sequencer
    import rtc_bus_pkg::*;
#(
    parameter int unsigned T_SETUP = 2,
    parameter int unsigned T_PULSE = 4,
    parameter int unsigned T_HOLD  = 2,
    parameter int unsigned CNT_W   = 4
) (
    input  logic       reloj,
    input  logic       resetM_n,
    input  logic [1:0] Control,
    input  logic [7:0] wr_data,
    input  logic [7:0] ad_in,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       rtc_cs_n,
    output logic       rtc_rd_n,
    output logic       rtc_wr_n,
    output logic       rtc_a_d,
    output logic [3:0] reg_idx,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       busy,
    output logic       frame_done
);

    state_e           state;
    ctl_e             frame;
    logic             advance;
    logic             zero;
    logic [CNT_W-1:0] load_val;
    logic             is_read;
    logic [3:0]       last_idx;

    assign is_read  = (frame == CtlL);
    assign last_idx = (frame == CtlI) ? InitLast : TimeLast;

    // Timer is reloaded with the length of the phase being entered on every transition.
    always_comb begin
        advance  = zero;
        load_val = CNT_W'(T_SETUP - 1);
        case (state)
            StIdle:         advance  = (ctl_e'(Control) != CtlMs);
            StASet, StDSet: load_val = CNT_W'(T_PULSE - 1);
            StAStb, StDStb: load_val = CNT_W'(T_HOLD - 1);
            StDHld:         load_val = '0;
            default:        ;
        endcase
    end

    rtc_bus_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk     (reloj),
        .rst_n   (resetM_n),
        .load    (advance),
        .load_val(load_val),
        .zero    (zero)
    );

    always_ff @(posedge reloj or negedge resetM_n) begin
        if (!resetM_n) begin
            state      <= StIdle;
            frame      <= CtlI;
            ad_out     <= '0;
            ad_oe      <= 1'b0;
            rtc_cs_n   <= 1'b1;
            rtc_rd_n   <= 1'b1;
            rtc_wr_n   <= 1'b1;
            rtc_a_d    <= 1'b0;
            reg_idx    <= '0;
            rd_data    <= '0;
            rd_valid   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            rd_valid   <= 1'b0;
            frame_done <= 1'b0;
            if (advance) begin
                case (state)
                    StIdle: begin
                        frame    <= ctl_e'(Control);
                        reg_idx  <= '0;
                        busy     <= 1'b1;
                        rtc_cs_n <= 1'b0;
                        rtc_a_d  <= 1'b0;
                        ad_oe    <= 1'b1;
                        ad_out   <= frame_addr(ctl_e'(Control), 4'd0);
                        state    <= StASet;
                    end
                    StASet: begin
                        rtc_wr_n <= 1'b0;
                        state    <= StAStb;
                    end
                    StAStb: begin
                        rtc_wr_n <= 1'b1;
                        state    <= StAHld;
                    end
                    StAHld: begin
                        rtc_a_d <= 1'b1;
                        if (is_read) begin
                            ad_oe <= 1'b0;
                        end else if (frame == CtlE) begin
                            ad_out <= wr_data;
                        end else begin
                            ad_out <= init_data(reg_idx[1:0]);
                        end
                        state <= StDSet;
                    end
                    StDSet: begin
                        if (is_read) begin
                            rtc_rd_n <= 1'b0;
                        end else begin
                            rtc_wr_n <= 1'b0;
                        end
                        state <= StDStb;
                    end
                    StDStb: begin
                        rtc_rd_n <= 1'b1;
                        rtc_wr_n <= 1'b1;
                        if (is_read) begin
                            rd_data  <= ad_in;
                            rd_valid <= 1'b1;
                        end
                        state <= StDHld;
                    end
                    StDHld: begin
                        rtc_cs_n <= 1'b1;
                        rtc_a_d  <= 1'b0;
                        ad_oe    <= 1'b0;
                        state    <= StNext;
                    end
                    StNext: begin
                        if (reg_idx == last_idx) begin
                            busy       <= 1'b0;
                            frame_done <= 1'b1;
                            state      <= StIdle;
                        end else begin
                            reg_idx  <= reg_idx + 4'd1;
                            rtc_cs_n <= 1'b0;
                            ad_oe    <= 1'b1;
                            ad_out   <= frame_addr(frame, reg_idx + 4'd1);
                            state    <= StASet;
                        end
                    end
                    default: state <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Directed bench for rtc_bus_sequencer: reset, I/L/E frames, Control changes, back-to-back.
// Expected register count follows RTC_TIMER_EN.
`timescale 1ns/1ps
module tb_rtc_bus_sequencer;

`ifdef RTC_TIMER_EN
    localparam int NREG = 9;
`else
    localparam int NREG = 6;
`endif

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] ctl   = 2'b11;
    logic [7:0] wr_data, ad_in, ad_out, rd_data;
    logic       ad_oe, cs_n, rd_n, wr_n, a_d, rd_valid, busy, frame_done;
    logic [3:0] reg_idx;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // Upstream models: write byte tracks reg_idx, pad drives a marker only while RD_n is low.
    assign wr_data = 8'h30 + {4'h0, reg_idx};
    assign ad_in   = rd_n ? 8'hEE : (8'h59 + {4'h0, reg_idx});

    rtc_bus_sequencer dut (
        .reloj     (clk),
        .resetM_n  (rst_n),
        .Control   (ctl),
        .wr_data   (wr_data),
        .ad_in     (ad_in),
        .ad_out    (ad_out),
        .ad_oe     (ad_oe),
        .rtc_cs_n  (cs_n),
        .rtc_rd_n  (rd_n),
        .rtc_wr_n  (wr_n),
        .rtc_a_d   (a_d),
        .reg_idx   (reg_idx),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .busy      (busy),
        .frame_done(frame_done)
    );

    int cyc = 0, n_addr = 0, n_wd = 0, n_rd = 0, n_done = 0, n_41 = 0, n_rdlow = 0, viol = 0;
    int rise_cyc = 0, done_cyc = 0, wr_run = 0, rd_run = 0;
    logic wr_prev = 1'b1, busy_prev = 1'b0;
    logic [7:0] addr_log [0:255];
    logic [7:0] wd_log   [0:255];
    logic [7:0] rd_log   [0:255];
    logic [3:0] rdi_log  [0:255];
    logic bad_both, bad_oe, bad_cs, bad_wlen, bad_rlen;

    assign bad_both = !rd_n && !wr_n;
    assign bad_oe   = !rd_n && ad_oe;
    assign bad_cs   = (!rd_n || !wr_n) && cs_n;
    assign bad_wlen = wr_n && (wr_run != 0) && (wr_run != 4);
    assign bad_rlen = rd_n && (rd_run != 0) && (rd_run != 4);

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst_n) begin
            wr_run    <= 0;
            rd_run    <= 0;
            wr_prev   <= 1'b1;
            busy_prev <= 1'b0;
        end else begin
            viol <= viol + int'(bad_both) + int'(bad_oe) + int'(bad_cs) + int'(bad_wlen)
                    + int'(bad_rlen);
            wr_run    <= wr_n ? 0 : wr_run + 1;
            rd_run    <= rd_n ? 0 : rd_run + 1;
            wr_prev   <= wr_n;
            busy_prev <= busy;
            if (!rd_n) n_rdlow <= n_rdlow + 1;
            if (ad_out == 8'h41) n_41 <= n_41 + 1;
            if (!wr_n && wr_prev) begin
                if (!a_d) begin
                    addr_log[n_addr % 256] <= ad_out;
                    n_addr <= n_addr + 1;
                end else begin
                    wd_log[n_wd % 256] <= ad_out;
                    n_wd <= n_wd + 1;
                end
            end
            if (rd_valid) begin
                rd_log[n_rd % 256]  <= rd_data;
                rdi_log[n_rd % 256] <= reg_idx;
                n_rd <= n_rd + 1;
            end
            if (frame_done) begin
                n_done   <= n_done + 1;
                done_cyc <= cyc;
            end
            if (busy && !busy_prev) rise_cyc <= cyc;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic start_frame(input logic [1:0] c);
        int k;
        k = 0;
        ctl = c;
        while (!busy && k < 10) begin tick(); k++; end
        ctl = 2'b11;
        tests++;
        if (!busy) begin fails++; $display("FAIL start_%0d: busy=%b required 1", c, busy); end
    endtask

    task automatic wait_done(input int nd);
        int k;
        k = 0;
        while (n_done == nd && k < 300) begin tick(); k++; end
        tests++;
        if (n_done != nd + 1) begin
            fails++; $display("FAIL frame_done_count: got %0d required %0d", n_done - nd, 1);
        end
    endtask

    task automatic test_reset();
        logic [29:0] got;
        tick(); tick();
        got = {cs_n, rd_n, wr_n, a_d, ad_oe, ad_out, rd_data, reg_idx, rd_valid, busy, frame_done};
        tests++;
        if (got !== {5'b11100, 8'h00, 8'h00, 4'h0, 3'b000}) begin
            fails++; $display("FAIL reset_state: got %h required %h", got,
                              {5'b11100, 8'h00, 8'h00, 4'h0, 3'b000});
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_init_frame();
        int na, nw, nr, nd;
        na = n_addr; nw = n_wd; nr = n_rd; nd = n_done;
        start_frame(2'b00);
        wait_done(nd);
        tests++; if (n_addr - na != 4) begin fails++; $display("FAIL init_addr_cnt: got %0d required 4", n_addr - na); end
        tests++; if (addr_log[na % 256] !== 8'h02) begin fails++; $display("FAIL init_addr0: got %h required 02", addr_log[na % 256]); end
        tests++; if (wd_log[nw % 256] !== 8'h10) begin fails++; $display("FAIL init_data0: got %h required 10", wd_log[nw % 256]); end
        tests++; if (addr_log[(na + 2) % 256] !== 8'h10) begin fails++; $display("FAIL init_addr2: got %h required 10", addr_log[(na + 2) % 256]); end
        tests++; if (wd_log[(nw + 2) % 256] !== 8'hD2) begin fails++; $display("FAIL init_data2: got %h required D2", wd_log[(nw + 2) % 256]); end
        tests++; if (addr_log[(na + 3) % 256] !== 8'h00) begin fails++; $display("FAIL init_addr3: got %h required 00", addr_log[(na + 3) % 256]); end
        tests++; if (done_cyc - rise_cyc != 68) begin fails++; $display("FAIL init_length: got %0d required 68", done_cyc - rise_cyc); end
        tests++; if (n_rd != nr) begin fails++; $display("FAIL init_no_read: got %0d required 0", n_rd - nr); end
        tick();
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL init_busy_end: got %b required 0", busy); end
    endtask

    task automatic test_read_frame();
        int na, nw, nr, nd, n41;
        na = n_addr; nw = n_wd; nr = n_rd; nd = n_done; n41 = n_41;
        start_frame(2'b01);
        wait_done(nd);
        tests++; if (n_rd - nr != NREG) begin fails++; $display("FAIL read_cnt: got %0d required %0d", n_rd - nr, NREG); end
        tests++; if (rd_log[nr % 256] !== 8'h59) begin fails++; $display("FAIL read_data0: got %h required 59", rd_log[nr % 256]); end
        tests++; if (rdi_log[nr % 256] !== 4'd0) begin fails++; $display("FAIL read_idx0: got %0d required 0", rdi_log[nr % 256]); end
        tests++; if (rd_log[(nr + NREG - 1) % 256] !== 8'(8'h59 + NREG - 1)) begin fails++; $display("FAIL read_data_last: got %h required %h", rd_log[(nr + NREG - 1) % 256], 8'(8'h59 + NREG - 1)); end
        tests++; if (rdi_log[(nr + NREG - 1) % 256] !== 4'(NREG - 1)) begin fails++; $display("FAIL read_idx_last: got %0d required %0d", rdi_log[(nr + NREG - 1) % 256], NREG - 1); end
        tests++; if (addr_log[(na + 5) % 256] !== 8'h26) begin fails++; $display("FAIL read_addr5: got %h required 26", addr_log[(na + 5) % 256]); end
        tests++; if (n_wd != nw) begin fails++; $display("FAIL read_no_write: got %0d required 0", n_wd - nw); end
`ifdef RTC_TIMER_EN
        tests++; if (addr_log[(na + 6) % 256] !== 8'h41) begin fails++; $display("FAIL read_addr6: got %h required 41", addr_log[(na + 6) % 256]); end
`else
        tests++; if (n_41 != n41) begin fails++; $display("FAIL read_no_41: got %0d cycles required 0", n_41 - n41); end
`endif
        tick();
    endtask

    task automatic test_prog_frame();
        int na, nw, nd, nlow;
        logic [7:0] ea;
        na = n_addr; nw = n_wd; nd = n_done; nlow = n_rdlow;
        start_frame(2'b10);
        wait_done(nd);
        tests++; if (n_wd - nw != NREG) begin fails++; $display("FAIL prog_cnt: got %0d required %0d", n_wd - nw, NREG); end
        for (int i = 0; i < NREG; i++) begin
            ea = (i < 6) ? 8'(8'h21 + i) : 8'(8'h41 + i - 6);
            tests++;
            if (addr_log[(na + i) % 256] !== ea || wd_log[(nw + i) % 256] !== 8'(8'h30 + i)) begin
                fails++; $display("FAIL prog_entry%0d: got %h/%h required %h/%h", i,
                                  addr_log[(na + i) % 256], wd_log[(nw + i) % 256], ea, 8'(8'h30 + i));
            end
        end
        tests++; if (n_rdlow != nlow) begin fails++; $display("FAIL prog_rd_low: got %0d required 0", n_rdlow - nlow); end
        tick();
    endtask

    task automatic test_control_change();
        int nr, nd, k, rc;
        nr = n_rd; nd = n_done; k = 0;
        ctl = 2'b01;
        while (!(busy && reg_idx == 4'd3) && k < 200) begin tick(); k++; end
        ctl = 2'b11;
        wait_done(nd);
        tests++; if (n_rd - nr != NREG) begin fails++; $display("FAIL ctl_read_cnt: got %0d required %0d", n_rd - nr, NREG); end
        rc = rise_cyc;
        for (int i = 0; i < 5; i++) tick();
        tests++;
        if (cs_n !== 1'b1 || busy !== 1'b0 || rise_cyc != rc) begin
            fails++; $display("FAIL ctl_idle: got cs_n=%b busy=%b required 1/0", cs_n, busy);
        end
    endtask

    task automatic test_back_to_back();
        int na, nd, k, d1;
        na = n_addr; nd = n_done; k = 0;
        ctl = 2'b00;
        while (n_done == nd && k < 200) begin tick(); k++; end
        d1 = done_cyc;
        k = 0;
        while (rise_cyc <= d1 && k < 10) begin tick(); k++; end
        tests++; if (rise_cyc - d1 != 1) begin fails++; $display("FAIL b2b_gap: got %0d required 1", rise_cyc - d1); end
        ctl = 2'b11;
        wait_done(nd + 1);
        tests++; if (n_addr - na != 8) begin fails++; $display("FAIL b2b_addr_cnt: got %0d required 8", n_addr - na); end
        tick();
    endtask

    task automatic test_reset_mid_strobe();
        int k;
        k = 0;
        ctl = 2'b10;
        while (!(busy && a_d && !wr_n) && k < 100) begin tick(); k++; end
        ctl = 2'b11;
        tests++; if (k >= 100) begin fails++; $display("FAIL mid_wait: got timeout required data strobe"); end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({wr_n, cs_n, ad_oe, busy} !== 4'b1100) begin
            fails++; $display("FAIL mid_reset: got wr_n,cs_n,ad_oe,busy=%b required 1100",
                              {wr_n, cs_n, ad_oe, busy});
        end
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_protocol();
        tests++;
        if (viol != 0) begin fails++; $display("FAIL protocol: got %0d violations required 0", viol); end
    endtask

    initial begin
        test_reset();
        test_init_frame();
        test_read_frame();
        test_prog_frame();
        test_control_change();
        test_back_to_back();
        test_reset_mid_strobe();
        test_protocol();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
